output_gain_stage: RTL and testbench
====================================

# output_gain_stage

Master output stage placed directly downstream of the 48 kHz FIR lowpass. It takes one filtered 16-bit sample per `sample_clk` and applies a zipper-free ramped volume. It also provides click-free mute fade-out and fade-in, output saturation with clip reporting, and a peak-hold level meter for the PS-side UI. Its `sample_out` feeds the I2S transmitter.

## Interface
- `RAMP_STEP`, 32: maximum gain change per sample, in Q1.15 LSBs.
- `PEAK_HOLD`, 4800: number of samples the peak is held before decay begins (100 ms).
- `PEAK_DECAY_SHIFT`, 4: per-sample peak decay equals `peak >> PEAK_DECAY_SHIFT`, with a minimum of 1.

Ports:
- `sample_clk` in 1: sample-rate clock. All logic runs on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `sample_in` in 16: signed sample from the lowpass.
- `target_gain` in 16: unsigned Q1.15 gain. 0x8000 is unity; 0xFFFF is about 2.0.
- `mute` in 1: level-sensitive mute request.
- `clip_clr` in 1: synchronous clear of `clip_count`.
- `sample_out` out 16: signed gained, saturated sample.
- `cur_gain` out 16: gain currently applied.
- `muted` out 1: high while the state is MUTED.
- `clip` out 1: high for the cycle whose `sample_out` was saturated.
- `clip_count` out 16: saturating count of clipped samples.
- `peak` out 15: peak-hold of |`sample_out`|.

## Operation
- **State machine:** MUTED, FADE_IN, ACTIVE, FADE_OUT.
  - MUTED: if `mute`=0, go to FADE_IN. `cur_gain` stays 0 on the transition edge.
  - FADE_IN: if `mute`=1, go to FADE_OUT. Otherwise step toward `target_gain`. When `cur_gain` equals `target_gain` after the step, go to ACTIVE.
  - ACTIVE: if `mute`=1, go to FADE_OUT. Otherwise step toward `target_gain`; target changes are chased at the ramp rate.
  - FADE_OUT: if `mute`=0, go to FADE_IN. Otherwise step toward 0. If `cur_gain` ≤ `RAMP_STEP`, then `cur_gain` becomes 0 and the state becomes MUTED on the same edge.
- **Step rule:** if |target − g| ≤ `RAMP_STEP`, set g = target. Otherwise move g by ±`RAMP_STEP`. Compute in 17 bits so that no wrap is possible.
- **Retargeting during a fade:** a `target_gain` change in FADE_IN retargets the ramp. If `target_gain`=0 in FADE_IN, go to ACTIVE once g=0.
- **Gain arithmetic:**
  - Multiply signed `sample_in` by zero-extended 17-bit `cur_gain`, giving a 33-bit signed product.
  - Arithmetic-shift right by 15 (floor).
  - Saturate to [−32768, 32767]. `clip`=1 whenever saturation occurs.
  - The multiply uses the `cur_gain` value before the same edge's ramp update.
- **Clip counter:** `clip_count` increments on each `clip` cycle and holds at 0xFFFF. When `clip_clr` is high, the count is set to 0, or to 1 if `clip` is high in the same cycle.
- **Peak meter:**
  - a = |`sample_out`|, saturated, so −32768 gives 32767.
  - If a ≥ `peak`: `peak` = a and the hold counter reloads to `PEAK_HOLD`.
  - Else if the hold counter > 0: decrement the hold counter.
  - Else: `peak` −= max(`peak` >> `PEAK_DECAY_SHIFT`, 1), floored at 0.
- **Reset values:**
  - `sample_out`=0, `cur_gain`=0, `muted`=1, `clip`=0, `clip_count`=0, `peak`=0.
  - State is MUTED and the hold counter is 0.
  - A reset asserted mid-fade forces these values on the next edge.

## Timing
- The data path has 1-cycle latency. `sample_out` at edge k+1 is the result for `sample_in` sampled at edge k.
- `clip` is aligned with the `sample_out` it describes. `peak` and `clip_count` lag that `sample_out` by one edge.
- Each ramp step takes one edge. A full unity fade takes 0x8000 / `RAMP_STEP` = 1024 edges, about 21.3 ms.
- `muted` is registered together with the state and changes on the same edge as the transition.
- There is no handshake: exactly one sample is consumed and one is produced per edge.
- When `mute` and `target_gain` change on the same edge, the state transition is decided first. The step direction then follows the new state.

## Test plan
1. **Fade-in from reset.** Release `rst` with `mute`=0 and `target_gain`=0x8000. Required: `muted` falls on edge 1; `cur_gain` = 32·n at edge 1+n; it reaches 0x8000 at edge 1025; the state becomes ACTIVE.
2. **Gain arithmetic at unity and half.** At unity, `sample_in`=1000 → `sample_out`=1000. With g=0x4000, `sample_in`=−3 → −2 (floor). With g=0x4000, `sample_in`=−32768 → −16384, and `clip`=0.
3. **Saturation.** With g=0xFFFF, `sample_in`=20000 → 32767, `clip`=1. With g=0xFFFF, `sample_in`=−20000 → −32768, `clip`=1. `clip_count`=2. Pulsing `clip_clr` on a clipping cycle leaves `clip_count`=1.
4. **Mute round trip.** From ACTIVE at 0x8000, assert `mute`. Required: `cur_gain` reaches 0 and `muted`=1 on the 1024th edge. Deassert `mute` at g=0x4000. Required: the state goes to FADE_IN, g reverses, and no output step exceeds the ramp rate.
5. **Peak hold and decay.** Drive one sample whose output is 16000, then zeros. Required: `peak`=16000 for 4800 edges, then 15000, then 14063, and so on down to 0.
6. **Reset mid-fade.** Assert `rst` at g=0x3000 in FADE_OUT. Required: the next edge gives all reset values, with `muted`=1 and `cur_gain`=0.

Source files
------------

// File: rtl/output_gain_stage.sv
// output_gain_stage: ramped master volume with mute fades, saturation, clip count and peak-hold meter
module output_gain_stage #(
  parameter int RAMP_STEP        = 32,
  parameter int PEAK_HOLD        = 4800,
  parameter int PEAK_DECAY_SHIFT = 4
) (
  input  logic               sample_clk,
  input  logic               rst,
  input  logic signed [15:0] sample_in,
  input  logic        [15:0] target_gain,
  input  logic               mute,
  input  logic               clip_clr,
  output logic signed [15:0] sample_out,
  output logic        [15:0] cur_gain,
  output logic               muted,
  output logic               clip,
  output logic        [15:0] clip_count,
  output logic        [14:0] peak
);
  localparam int HW = $clog2(PEAK_HOLD + 1);
  localparam logic [16:0] RS17 = 17'(RAMP_STEP);
  localparam logic [15:0] RS16 = 16'(RAMP_STEP);
  localparam logic signed [32:0] MAX_S = 33'sd32767;
  localparam logic signed [32:0] MIN_S = -33'sd32768;
  typedef enum logic [1:0] {MUTED, FADE_IN, ACTIVE, FADE_OUT} state_t;
  state_t state, state_nx;
  logic [15:0] gain_nx;
  logic [HW-1:0] hold;
  logic signed [32:0] prod, shifted;
  logic signed [15:0] sat_out;
  logic sat;
  logic [15:0] mag_raw;
  logic [14:0] mag, decay, dec, peak_dec;
  function automatic logic [15:0] step_to(input logic [15:0] g, input logic [15:0] t);
    logic [16:0] g17, t17;
    g17 = {1'b0, g};
    t17 = {1'b0, t};
    return (t17 > g17 + RS17) ? g + RS16 : (g17 > t17 + RS17) ? g - RS16 : t;
  endfunction
  assign muted = (state == MUTED);
  assign prod = 33'(sample_in) * 33'($signed({1'b0, cur_gain}));
  assign shifted = prod >>> 15;
  assign sat = (shifted > MAX_S) || (shifted < MIN_S);
  assign sat_out = (shifted > MAX_S) ? 16'sh7FFF : (shifted < MIN_S) ? 16'sh8000 : shifted[15:0];
  assign mag_raw = sample_out[15] ? -sample_out : sample_out;
  assign mag = mag_raw[15] ? 15'h7FFF : mag_raw[14:0];
  assign decay = peak >> PEAK_DECAY_SHIFT;
  assign dec = (decay == '0) ? 15'd1 : decay;
  assign peak_dec = (peak > dec) ? peak - dec : '0;
  // next state and next gain; transition is decided first, then the step follows the new state
  always_comb begin
    state_nx = state;
    gain_nx = cur_gain;
    case (state)
      MUTED: begin
        state_nx = mute ? MUTED : FADE_IN;
        gain_nx = '0;
      end
      FADE_IN: begin
        gain_nx = step_to(cur_gain, mute ? 16'd0 : target_gain);
        state_nx = mute ? FADE_OUT : (gain_nx == target_gain) ? ACTIVE : FADE_IN;
      end
      ACTIVE: begin
        state_nx = mute ? FADE_OUT : ACTIVE;
        gain_nx = step_to(cur_gain, mute ? 16'd0 : target_gain);
      end
      FADE_OUT: begin
        state_nx = !mute ? FADE_IN : (cur_gain <= RS16) ? MUTED : FADE_OUT;
        gain_nx = !mute ? step_to(cur_gain, target_gain) : (cur_gain <= RS16) ? 16'd0 : cur_gain - RS16;
      end
      default: begin
        state_nx = MUTED;
        gain_nx = '0;
      end
    endcase
  end
  // state and gain register; the multiply uses the pre-update gain
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      state <= MUTED;
      cur_gain <= '0;
    end else begin
      state <= state_nx;
      cur_gain <= gain_nx;
    end
  end
  // gained, saturated output with clip flag aligned to it
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      sample_out <= '0;
      clip <= 1'b0;
    end else begin
      sample_out <= sat_out;
      clip <= sat;
    end
  end
  // saturating clip counter, cleared to the current clip flag
  always_ff @(posedge sample_clk) begin
    if (rst) clip_count <= '0;
    else clip_count <= clip_clr ? {15'd0, clip} : (clip && clip_count != 16'hFFFF) ? clip_count + 16'd1 : clip_count;
  end
  // peak hold with proportional decay after the hold window
  always_ff @(posedge sample_clk) begin
    if (rst) begin
      peak <= '0;
      hold <= '0;
    end else if (mag >= peak) begin
      peak <= mag;
      hold <= HW'(PEAK_HOLD);
    end else if (hold != '0) begin
      hold <= hold - HW'(1);
    end else begin
      peak <= peak_dec;
    end
  end
endmodule

// File: tb/tb_output_gain_stage.sv
// tb_output_gain_stage: scoreboard bench with a behavioural model of the gain stage
module tb_output_gain_stage;
  logic sample_clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic [15:0] target_gain = 16'h8000;
  logic mute = 1'b0;
  logic clip_clr = 1'b0;
  logic signed [15:0] sample_out;
  logic [15:0] cur_gain, clip_count;
  logic muted, clip;
  logic [14:0] peak;

  output_gain_stage dut (
    .sample_clk(sample_clk), .rst(rst), .sample_in(sample_in), .target_gain(target_gain),
    .mute(mute), .clip_clr(clip_clr), .sample_out(sample_out), .cur_gain(cur_gain),
    .muted(muted), .clip(clip), .clip_count(clip_count), .peak(peak)
  );

  always #5 sample_clk = ~sample_clk;

  typedef struct {
    int out;
    int gain;
    int muted;
    int clip;
    int cnt;
    int peak;
    bit rst;
  } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  localparam int ST_MUTED = 0, ST_IN = 1, ST_ACT = 2, ST_OUT = 3;
  int m_st = ST_MUTED, m_g = 0, m_out = 0, m_clip = 0, m_cnt = 0, m_peak = 0, m_hold = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int toward(input int g, input int t);
    if (t - g <= 32 && g - t <= 32) return t;
    return (t > g) ? g + 32 : g - 32;
  endfunction

  task automatic model_step();
    int n_st, n_g, n_out, n_clip, n_cnt, n_peak, n_hold, a, d, tgt;
    longint p, q;
    exp_t e;
    if (rst) begin
      n_st = ST_MUTED; n_g = 0; n_out = 0; n_clip = 0; n_cnt = 0; n_peak = 0; n_hold = 0;
    end else begin
      tgt = int'(target_gain);
      p = longint'(sample_in) * longint'(m_g);
      q = p / 32768;
      if (p < 0 && q * 32768 != p) q = q - 1;
      n_clip = (q > 32767 || q < -32768) ? 1 : 0;
      n_out = (q > 32767) ? 32767 : (q < -32768) ? -32768 : int'(q);
      if (clip_clr) n_cnt = m_clip;
      else n_cnt = (m_clip == 1 && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      a = (m_out < 0) ? -m_out : m_out;
      if (a > 32767) a = 32767;
      n_peak = m_peak;
      n_hold = m_hold;
      if (a >= m_peak) begin
        n_peak = a;
        n_hold = 4800;
      end else if (m_hold > 0) begin
        n_hold = m_hold - 1;
      end else begin
        d = m_peak / 16;
        if (d < 1) d = 1;
        n_peak = (m_peak > d) ? m_peak - d : 0;
      end
      n_st = m_st;
      n_g = m_g;
      if (m_st == ST_MUTED) begin
        if (!mute) n_st = ST_IN;
      end else if (m_st == ST_IN) begin
        if (mute) begin
          n_st = ST_OUT;
          n_g = toward(m_g, 0);
        end else begin
          n_g = toward(m_g, tgt);
          if (n_g == tgt) n_st = ST_ACT;
        end
      end else if (m_st == ST_ACT) begin
        if (mute) n_st = ST_OUT;
        n_g = toward(m_g, mute ? 0 : tgt);
      end else begin
        if (!mute) begin
          n_st = ST_IN;
          n_g = toward(m_g, tgt);
        end else if (m_g <= 32) begin
          n_st = ST_MUTED;
          n_g = 0;
        end else begin
          n_g = m_g - 32;
        end
      end
    end
    m_st = n_st; m_g = n_g; m_out = n_out; m_clip = n_clip; m_cnt = n_cnt; m_peak = n_peak; m_hold = n_hold;
    e.out = m_out; e.gain = m_g; e.muted = (m_st == ST_MUTED) ? 1 : 0; e.clip = m_clip;
    e.cnt = m_cnt; e.peak = m_peak; e.rst = rst;
    sb.push_back(e);
  endtask

  task automatic tick();
    model_step();
    started = 1'b1;
    @(negedge sample_clk);
  endtask

  task automatic ramp_to(input logic [15:0] tgt, input string name);
    target_gain = tgt;
    for (int i = 0; i < 5000 && !(m_g == int'(tgt) && m_st == ST_ACT); i++) begin
      sample_in = 16'($urandom);
      tick();
    end
    chk(name, int'(cur_gain), int'(tgt));
  endtask

  // monitor: pop the expected response for every edge and compare
  initial begin
    exp_t e;
    int prev_gain;
    bit have_prev;
    have_prev = 1'b0;
    prev_gain = 0;
    forever begin
      @(posedge sample_clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sample_out", int'(sample_out), e.out);
        chk("cur_gain", int'(cur_gain), e.gain);
        chk("muted", int'(muted), e.muted);
        chk("clip", int'(clip), e.clip);
        chk("clip_count", int'(clip_count), e.cnt);
        chk("peak", int'(peak), e.peak);
        if (have_prev && !e.rst)
          chk("ramp_rate_ok", (int'(cur_gain) - prev_gain <= 32 && prev_gain - int'(cur_gain) <= 32) ? 1 : 0, 1);
        prev_gain = int'(cur_gain);
        have_prev = 1'b1;
      end else if (started) begin
        chk("scoreboard_empty", 0, 1);
      end
    end
  end

  // stimulus
  initial begin
    @(negedge sample_clk);
    tick();
    tick();
    chk("reset_muted", int'(muted), 1);
    chk("reset_gain", int'(cur_gain), 0);
    rst = 1'b0;
    tick();
    chk("fade_in_edge1_muted", int'(muted), 0);
    chk("fade_in_edge1_gain", int'(cur_gain), 0);
    for (int n = 1; n <= 1024; n++) begin
      sample_in = 16'($urandom);
      tick();
      if (n == 1) chk("fade_in_edge2_gain", int'(cur_gain), 32);
    end
    chk("fade_in_unity", int'(cur_gain), 32768);
    sample_in = 16'sd1000;
    tick();
    chk("unity_1000", int'(sample_out), 1000);
    ramp_to(16'h4000, "ramp_half");
    sample_in = -16'sd3;
    tick();
    chk("half_neg3", int'(sample_out), -2);
    sample_in = 16'sh8000;
    tick();
    chk("half_min", int'(sample_out), -16384);
    chk("half_min_clip", int'(clip), 0);
    ramp_to(16'hFFFF, "ramp_max");
    sample_in = '0;
    tick();
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    sample_in = 16'sd20000;
    tick();
    chk("sat_pos", int'(sample_out), 32767);
    chk("sat_pos_clip", int'(clip), 1);
    sample_in = -16'sd20000;
    tick();
    chk("sat_neg", int'(sample_out), -32768);
    chk("sat_neg_clip", int'(clip), 1);
    sample_in = '0;
    tick();
    chk("clip_count_two", int'(clip_count), 2);
    sample_in = 16'sd20000;
    tick();
    sample_in = '0;
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    chk("clip_clr_on_clip", int'(clip_count), 1);
    for (int i = 0; i < 3000; i++) begin
      sample_in = 16'($urandom);
      if ($urandom_range(0, 199) == 0) mute = ~mute;
      if ($urandom_range(0, 249) == 0)
        case ($urandom_range(0, 4))
          0: target_gain = 16'h0000;
          1: target_gain = 16'h2000;
          2: target_gain = 16'h8000;
          3: target_gain = 16'hFFFF;
          default: target_gain = 16'($urandom);
        endcase
      clip_clr = ($urandom_range(0, 49) == 0);
      tick();
    end
    mute = 1'b0;
    clip_clr = 1'b0;
    ramp_to(16'h8000, "mute_trip_start");
    mute = 1'b1;
    repeat (1023) tick();
    chk("fade_out_1023_gain", int'(cur_gain), 32);
    chk("fade_out_1023_muted", int'(muted), 0);
    tick();
    chk("fade_out_1024_gain", int'(cur_gain), 0);
    chk("fade_out_1024_muted", int'(muted), 1);
    mute = 1'b0;
    repeat (1025) tick();
    chk("refade_unity", int'(cur_gain), 32768);
    mute = 1'b1;
    repeat (512) tick();
    chk("fade_out_half", int'(cur_gain), 16384);
    mute = 1'b0;
    tick();
    chk("reverse_gain", int'(cur_gain), 16416);
    chk("reverse_muted", int'(muted), 0);
    repeat (20) tick();
    chk("reverse_climb", int'(cur_gain), 17056);
    rst = 1'b1;
    sample_in = '0;
    tick();
    rst = 1'b0;
    repeat (1025) tick();
    chk("peak_idle", int'(peak), 0);
    sample_in = 16'sd16000;
    tick();
    sample_in = '0;
    tick();
    chk("peak_load", int'(peak), 16000);
    repeat (4800) tick();
    chk("peak_hold_end", int'(peak), 16000);
    tick();
    chk("peak_decay1", int'(peak), 15000);
    tick();
    chk("peak_decay2", int'(peak), 14063);
    for (int i = 0; i < 3000 && m_peak != 0; i++) tick();
    chk("peak_floor", int'(peak), 0);
    sample_in = 16'sd30000;
    mute = 1'b1;
    repeat (640) tick();
    chk("mid_fade_gain", int'(cur_gain), 12288);
    chk("mid_fade_peak_nonzero", (peak != 0) ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_out", int'(sample_out), 0);
    chk("rst_mid_gain", int'(cur_gain), 0);
    chk("rst_mid_muted", int'(muted), 1);
    chk("rst_mid_clip", int'(clip), 0);
    chk("rst_mid_count", int'(clip_count), 0);
    chk("rst_mid_peak", int'(peak), 0);
    rst = 1'b0;
    mute = 1'b0;
    repeat (5) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
